fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side consumer stage for the async FIFO, located in the read clock domain.
- Drives the FIFO read port (en/data/empty) and presents the words as a valid/ready stream to downstream logic.
- Hides the FIFO's 1-cycle read latency using a small credit-managed output buffer, so throughput is one word per clock under no backpressure.
- Counts delivered words for debug/scoreboarding.

Parameters:
- DATA_WIDTH, 8, width of FIFO and stream data.
- BUF_DEPTH, 3, output buffer entries. Minimum 2. 3 is required for full throughput without a combinational m_ready->rd_en path.
- CNT_WIDTH, 16, width of word_count.

Ports:
- clk  in  1  read-domain clock (same as FIFO read clock).
- rst  in  1  synchronous, active-high reset.
- rd_en  out  1  FIFO read enable; one word popped per cycle asserted.
- rd_data  in  DATA_WIDTH  FIFO read data; valid the cycle after rd_en.
- rd_empty  in  1  FIFO empty; accurate for the current cycle.
- rd_almost_empty  in  1  FIFO almost empty; status only, drives rd_low.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data (buffer head).
- m_ready  in  1  downstream accept.
- rd_low  out  1  registered copy of rd_almost_empty.
- word_count  out  CNT_WIDTH  number of stream handshakes completed, wrapping.

Behaviour:
- All state updates on the rising edge of clk. rst is sampled synchronously and has priority over everything.
- Reset values:
  - rd_en=0 (forced low while rst=1).
  - m_valid=0, m_data=0.
  - rd_low=0, word_count=0.
  - Buffer occupancy occ=0, in-flight flag infl=0.
- State:
  - Circular buffer of BUF_DEPTH entries with head/tail pointers that wrap at BUF_DEPTH.
  - occ counter (0..BUF_DEPTH).
  - infl flag: a read was issued last cycle.
- rd_en = !rst && !rd_empty && (occ + infl < BUF_DEPTH). It depends only on registered state and rd_empty, never on m_ready.
- infl <= rd_en each cycle.
- Capture: when infl=1, rd_data is written at the tail and the tail advances.
- Pop: when m_valid && m_ready, the head advances and word_count increments.
- occ_next = occ + infl - pop. Simultaneous push and pop leaves occ unchanged.
- m_valid = (occ != 0). m_data = buffer[head]. Both are driven from registers.
- Latency: rd_en high in cycle T -> rd_data sampled at the end of T+1 -> m_valid/m_data visible in T+2 (when the buffer was empty).
- Stream rules:
  - m_data is held stable while m_valid && !m_ready.
  - Words leave in FIFO order with no duplication and no drop.
- Credit invariant: occ + infl <= BUF_DEPTH at all times, so overflow is impossible. The bench asserts this.
- rd_en is never asserted while rd_empty=1.
- word_count wraps from 2^CNT_WIDTH-1 to 0.
- rd_low <= rd_almost_empty (1-cycle registered).
- Reset mid-operation: buffer contents and any in-flight word are discarded; that FIFO word is lost (documented). The FIFO must be reset together with this block. In the cycle after rst deasserts, state is clean.

Test Plan:
1. Reset: hold rst 2 cycles with FIFO non-empty and m_ready=1 -> rd_en=0, m_valid=0, word_count=0 throughout; the first rd_en appears in the first cycle after rst falls.
2. Latency: FIFO holds single word 0xA5, m_ready=1 -> rd_en high exactly 1 cycle (T); m_valid=1 with m_data=0xA5 in T+2 only; word_count=1.
3. Streaming: 8 words 0x01..0x08, m_ready=1 -> rd_en high 8 consecutive cycles; m_valid high 8 consecutive cycles; data 0x01..0x08 in order; word_count=8.
4. Backpressure: 10 words, m_ready=0 -> rd_en asserted exactly 3 times, m_data stays 0x01. Then m_ready=1 -> all 10 words delivered in order at one per cycle (after refill), and the occ+infl<=3 invariant never fails.
5. Empty boundary: rd_empty=1 permanently with a free buffer, plus random m_ready -> rd_en never asserted, m_valid stays 0. Toggle rd_empty every other cycle -> no read issued while empty.
6. Mid-op reset and wrap: reset while 2 words are buffered -> m_valid=0 next cycle, and later words still arrive in order. Separately, 65537 transfers -> word_count=1.

Source files
------------

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus valid/ready output stream bundle
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_empty;
    logic                  rd_almost_empty;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output rd_en, m_valid, m_data,
        input  rd_data, rd_empty, rd_almost_empty, m_ready
    );

    modport slave (
        input  rd_en, m_valid, m_data,
        output rd_data, rd_empty, rd_almost_empty, m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - async FIFO read-side consumer with credit-managed output buffer
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rd_stream_if.master     bus,
    output logic                 rd_low,
    output logic [CNT_WIDTH-1:0] word_count
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W:0]   DEPTH_C  = (OCC_W + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [OCC_W-1:0]      occ;
    logic                  infl;
    logic                  pop;
    logic [OCC_W:0]        credit_used;

    // A read is only issued when a slot is guaranteed for it, so m_ready never reaches rd_en.
    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, infl};
    assign bus.rd_en   = !rst && !bus.rd_empty && (credit_used < DEPTH_C);
    assign bus.m_valid = (occ != '0);
    assign bus.m_data  = buf_mem[head];
    assign pop         = bus.m_valid && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            infl       <= 1'b0;
            rd_low     <= 1'b0;
            word_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            infl   <= bus.rd_en;
            rd_low <= bus.rd_almost_empty;
            if (infl) begin
                buf_mem[tail] <= bus.rd_data;
                tail          <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head       <= (head == LAST_PTR) ? '0 : head + 1'b1;
                word_count <= word_count + 1'b1;
            end
            occ <= occ + OCC_W'(infl) - OCC_W'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream with FIFO model and scoreboard
module tb_fifo_rd_stream;
    localparam int DW = 8;
    localparam int BD = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_low;
    logic [CW-1:0] word_count;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream #(
        .DATA_WIDTH(DW),
        .BUF_DEPTH (BD),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .rd_low    (rd_low),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_count = '0;
    int            outstanding = 0;
    bit            infl_m = 0;
    bit            started = 0;
    bit            force_empty = 0;
    bit            toggle_empty = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    logic          s_rst, s_rd_en, s_empty, s_valid, s_ready, s_ae;
    logic [DW-1:0] s_data;
    logic [DW-1:0] exp_word;
    bit            exp_rd_en, exp_valid;

    int n_rd, first_rd, last_rd, n_val, first_val, last_val;

    task automatic clr_stats();
        n_rd = 0; first_rd = 0; last_rd = 0;
        n_val = 0; first_val = 0; last_val = 0;
    endtask

    task automatic update_empty();
        bus.rd_empty = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DW'(base + i));
            exp_q.push_back(DW'(base + i));
        end
        update_empty();
    endtask

    // One clock: sample pre-edge, advance FIFO model and scoreboard, check registered outputs.
    task automatic cycle();
        #1;
        s_rst   = rst;
        s_rd_en = bus.rd_en;
        s_empty = bus.rd_empty;
        s_valid = bus.m_valid;
        s_ready = bus.m_ready;
        s_data  = bus.m_data;
        s_ae    = bus.rd_almost_empty;

        checks++;
        if (s_rd_en && s_empty) begin
            errors++;
            $display("FAIL rd_en_while_empty: rd_en=%0b rd_empty=%0b cyc=%0d", s_rd_en, s_empty, cyc);
        end
        if (s_rst) begin
            checks++;
            if (s_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL rd_en_in_reset: got %0b expected 0 cyc=%0d", s_rd_en, cyc);
            end
        end else if (started) begin
            exp_rd_en = !s_empty && (outstanding < BD);
            exp_valid = (outstanding - int'(infl_m)) != 0;
            checks++;
            if (s_rd_en !== exp_rd_en) begin
                errors++;
                $display("FAIL rd_en_credit: got %0b expected %0b cyc=%0d", s_rd_en, exp_rd_en, cyc);
            end
            checks++;
            if (s_valid !== exp_valid) begin
                errors++;
                $display("FAIL m_valid_occ: got %0b expected %0b cyc=%0d", s_valid, exp_valid, cyc);
            end
        end
        if (prev_stall) begin
            checks++;
            if (s_valid !== 1'b1 || s_data !== prev_data) begin
                errors++;
                $display("FAIL stall_hold: got valid=%0b data=%02h expected valid=1 data=%02h", s_valid, s_data, prev_data);
            end
        end
        if (!s_rst && s_valid && s_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %02h expected none cyc=%0d", s_data, cyc);
            end else begin
                exp_word = exp_q.pop_front();
                if (s_data !== exp_word) begin
                    errors++;
                    $display("FAIL stream_data: got %02h expected %02h cyc=%0d", s_data, exp_word, cyc);
                end
            end
        end
        if (s_rd_en) begin
            if (n_rd == 0) first_rd = cyc;
            last_rd = cyc;
            n_rd++;
        end
        if (s_valid) begin
            if (n_val == 0) first_val = cyc;
            last_val = cyc;
            n_val++;
        end

        @(posedge clk);
        #1;
        cyc++;
        if (s_rd_en && fifo_q.size() > 0) bus.rd_data = fifo_q.pop_front();
        else bus.rd_data = DW'($urandom);
        bus.rd_almost_empty = 1'($urandom);
        if (toggle_empty) force_empty = !force_empty;
        update_empty();

        if (s_rst) begin
            started     = 1;
            outstanding = 0;
            infl_m      = 0;
            exp_count   = '0;
            exp_q       = fifo_q;
            prev_stall  = 0;
            checks++;
            if (bus.m_valid !== 1'b0 || bus.m_data !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%0b data=%02h expected valid=0 data=00", bus.m_valid, bus.m_data);
            end
        end else begin
            outstanding += int'(s_rd_en) - int'(s_valid && s_ready);
            infl_m       = s_rd_en;
            if (s_valid && s_ready) exp_count++;
            prev_stall = s_valid && !s_ready;
            prev_data  = s_data;
        end
        checks++;
        if (outstanding < 0 || outstanding > BD) begin
            errors++;
            $display("FAIL credit_invariant: got occ+infl=%0d expected 0..%0d", outstanding, BD);
        end
        checks++;
        if (word_count !== exp_count) begin
            errors++;
            $display("FAIL word_count: got %0d expected %0d cyc=%0d", word_count, exp_count, cyc);
        end
        checks++;
        if (rd_low !== (s_rst ? 1'b0 : s_ae)) begin
            errors++;
            $display("FAIL rd_low: got %0b expected %0b", rd_low, s_rst ? 1'b0 : s_ae);
        end
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || outstanding != 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || outstanding != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clr_stats();
    endtask

    task automatic test_reset();
        load(3, 'h30);
        bus.m_ready = 1'b1;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        checks++;
        if (s_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL first_rd_after_reset: got %0b expected 1", s_rd_en);
        end
        drain(30);
    endtask

    task automatic test_latency();
        do_reset();
        bus.m_ready = 1'b1;
        load(1, 'hA5);
        repeat (6) cycle();
        checks++;
        if (n_rd != 1 || n_val != 1) begin
            errors++;
            $display("FAIL latency_counts: got rd=%0d val=%0d expected rd=1 val=1", n_rd, n_val);
        end
        checks++;
        if (first_val != first_rd + 2) begin
            errors++;
            $display("FAIL latency_gap: got %0d expected 2", first_val - first_rd);
        end
        checks++;
        if (word_count !== 16'd1) begin
            errors++;
            $display("FAIL latency_count: got %0d expected 1", word_count);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        bus.m_ready = 1'b1;
        load(8, 1);
        repeat (14) cycle();
        checks++;
        if (n_rd != 8 || last_rd - first_rd != 7) begin
            errors++;
            $display("FAIL stream_rd_en: got %0d reads over %0d cycles expected 8 over 8", n_rd, last_rd - first_rd + 1);
        end
        checks++;
        if (n_val != 8 || last_val - first_val != 7 || first_val != first_rd + 2) begin
            errors++;
            $display("FAIL stream_valid: got %0d valid from %0d expected 8 from %0d", n_val, first_val, first_rd + 2);
        end
        checks++;
        if (word_count !== 16'd8) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 8", word_count);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.m_ready = 1'b0;
        load(10, 1);
        repeat (8) cycle();
        checks++;
        if (n_rd != 3) begin
            errors++;
            $display("FAIL bp_reads: got %0d expected 3", n_rd);
        end
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h01) begin
            errors++;
            $display("FAIL bp_head: got valid=%0b data=%02h expected valid=1 data=01", bus.m_valid, bus.m_data);
        end
        clr_stats();
        bus.m_ready = 1'b1;
        repeat (16) cycle();
        checks++;
        if (n_val != 10 || last_val - first_val != 9) begin
            errors++;
            $display("FAIL bp_release: got %0d valid over %0d cycles expected 10 over 10", n_val, last_val - first_val + 1);
        end
        checks++;
        if (word_count !== 16'd10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 10", word_count);
        end
    endtask

    task automatic test_empty_boundary();
        do_reset();
        force_empty = 1;
        update_empty();
        repeat (12) begin
            bus.m_ready = 1'($urandom);
            cycle();
        end
        checks++;
        if (n_rd != 0 || n_val != 0) begin
            errors++;
            $display("FAIL empty_idle: got rd=%0d val=%0d expected 0 0", n_rd, n_val);
        end
        toggle_empty = 1;
        bus.m_ready  = 1'b1;
        load(4, 'h50);
        drain(60);
        toggle_empty = 0;
        force_empty  = 0;
        update_empty();
        checks++;
        if (n_rd != 4) begin
            errors++;
            $display("FAIL empty_toggle_reads: got %0d expected 4", n_rd);
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        bus.m_ready = 1'b0;
        load(6, 'h60);
        repeat (3) cycle();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h60) begin
            errors++;
            $display("FAIL midrst_pre: got valid=%0b data=%02h expected valid=1 data=60", bus.m_valid, bus.m_data);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: got %0b expected 0", bus.m_valid);
        end
        clr_stats();
        bus.m_ready = 1'b1;
        drain(40);
        checks++;
        if (word_count !== 16'd3 || n_val != 3) begin
            errors++;
            $display("FAIL midrst_after: got count=%0d val=%0d expected 3 3", word_count, n_val);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.m_ready = 1'b1;
        load(65537, 0);
        drain(65600);
        checks++;
        if (word_count !== 16'd1) begin
            errors++;
            $display("FAIL count_wrap: got %0d expected 1", word_count);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.m_ready         = 1'b0;
        bus.rd_data         = '0;
        bus.rd_almost_empty = 1'b0;
        update_empty();
        clr_stats();
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_midop_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
